pc_unit: RTL and testbench

PC_UNIT -- requirements
Module: pc_unit

---
 rtl/pc_unit.sv | 95 +++++++++
 tb/tb_pc_unit.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/pc_unit.sv
// Program counter unit: holds the fetch address and advances it sequentially
// or by branch/jump redirect. Counts retired advances and flags misaligned
// register jumps. Two-state run/halt control.
//
// state  | meaning
// RUN    | PC advances every cycle unless stalled or halting
// HALTED | PC and counter frozen until resume
module pc_unit #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter int          COUNT_W      = 32
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               stall,
  input  logic               halt,
  input  logic               resume,
  input  logic               branch_taken,
  input  logic [15:0]        branch_offset,
  input  logic               jump,
  input  logic [25:0]        jump_target,
  input  logic               jump_reg,
  input  logic [31:0]        reg_target,
  output logic [31:0]        pc,
  output logic [31:0]        pc_plus4,
  output logic               running,
  output logic               misaligned,
  output logic [COUNT_W-1:0] retired
);

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } state_t;

  state_t      state;
  logic [29:0] next_word;
  logic [29:0] branch_words;

  // Sequential address; wraps naturally modulo 2^32.
  assign pc_plus4 = pc + 32'd4;

  // Offset is in words, so sign-extend straight into the word-address domain.
  assign branch_words = {{14{branch_offset[15]}}, branch_offset};

  // Next word address, highest-priority redirect first. Working in word
  // addresses keeps pc[1:0] at zero by construction.
  always_comb begin
    next_word = pc_plus4[31:2];
    if (jump_reg) begin
      next_word = reg_target[31:2];
    end else if (jump) begin
      next_word = {pc_plus4[31:28], jump_target};
    end else if (branch_taken) begin
      next_word = pc_plus4[31:2] + branch_words;
    end
  end

  // Run/halt control with PC, counter and sticky misaligned flag updates.
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= RUN;
      running    <= 1'b1;
      pc         <= {RESET_VECTOR[31:2], 2'b00};
      retired    <= '0;
      misaligned <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (halt) begin
            state   <= HALTED;
            running <= 1'b0;
          end else if (!stall) begin
            pc      <= {next_word, 2'b00};
            retired <= retired + COUNT_W'(1);
            if (jump_reg && (reg_target[1:0] != 2'b00)) begin
              misaligned <= 1'b1;
            end
          end
        end
        HALTED: begin
          // Resume only re-enables; the first advance is on the following edge.
          if (resume) begin
            state   <= RUN;
            running <= 1'b1;
          end
        end
        default: begin
          state   <= RUN;
          running <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit: directed scenarios followed by random
// stimulus, all compared against a behavioural model of the PC rules.
module tb_pc_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic        stall;
  logic        halt;
  logic        resume;
  logic        branch_taken;
  logic [15:0] branch_offset;
  logic        jump;
  logic [25:0] jump_target;
  logic        jump_reg;
  logic [31:0] reg_target;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        running;
  logic        misaligned;
  logic [31:0] retired;

  int n_vec = 0;
  int n_err = 0;

  // reference model state
  logic [31:0] m_pc;
  logic        m_halted;
  logic        m_mis;
  logic [31:0] m_ret;

  pc_unit #(
    .RESET_VECTOR(32'h0000_0000),
    .COUNT_W     (32)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .stall        (stall),
    .halt         (halt),
    .resume       (resume),
    .branch_taken (branch_taken),
    .branch_offset(branch_offset),
    .jump         (jump),
    .jump_target  (jump_target),
    .jump_reg     (jump_reg),
    .reg_target   (reg_target),
    .pc           (pc),
    .pc_plus4     (pc_plus4),
    .running      (running),
    .misaligned   (misaligned),
    .retired      (retired)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    reset = 0; stall = 0; halt = 0; resume = 0;
    branch_taken = 0; branch_offset = '0;
    jump = 0; jump_target = '0;
    jump_reg = 0; reg_target = '0;
  endtask

  // Model one rising edge from the architectural rules.
  task automatic model_edge();
    int signed off;
    if (reset) begin
      m_pc = 32'h0; m_halted = 0; m_mis = 0; m_ret = 0;
    end else if (m_halted) begin
      if (resume) m_halted = 0;
    end else if (halt) begin
      m_halted = 1;
    end else if (!stall) begin
      if (jump_reg) begin
        m_pc = reg_target & 32'hFFFF_FFFC;
        if (reg_target % 4 != 0) m_mis = 1;
      end else if (jump) begin
        m_pc = ((m_pc + 32'd4) & 32'hF000_0000) | (32'(jump_target) * 4);
      end else if (branch_taken) begin
        off  = int'($signed(branch_offset));
        m_pc = m_pc + 32'd4 + 32'(off * 4);
      end else begin
        m_pc = m_pc + 32'd4;
      end
      m_ret = m_ret + 1;
    end
  endtask

  task automatic tick();
    @(posedge clock);
    model_edge();
    #1;
    chk("pc", pc, m_pc);
    chk("pc_plus4", pc_plus4, m_pc + 32'd4);
    chk("running", {31'b0, running}, {31'b0, !m_halted});
    chk("misaligned", {31'b0, misaligned}, {31'b0, m_mis});
    chk("retired", retired, m_ret);
  endtask

  task automatic goto_pc(input logic [31:0] a);
    idle(); jump_reg = 1; reg_target = a; tick(); idle();
  endtask

  initial begin
    idle();
    reset = 1;
    tick();
    chk("rst_pc", pc, 32'h0);
    chk("rst_retired", retired, 32'd0);
    idle();

    // idle advance 0x4, 0x8, 0xC
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk("seq_pc", pc, 32'(i * 4));
      chk("seq_retired", retired, 32'(i));
    end

    // backward and forward branches
    goto_pc(32'h100);
    branch_taken = 1; branch_offset = 16'hFFFE; tick();
    chk("branch_back", pc, 32'h0000_00FC);
    goto_pc(32'h100);
    branch_taken = 1; branch_offset = 16'h0004; tick();
    chk("branch_fwd", pc, 32'h0000_0114);

    // stall holds, redirect ignored
    idle(); stall = 1; jump = 1; jump_target = 26'h3FF; tick();
    chk("stall_hold", pc, 32'h0000_0114);
    // resume in RUN has no effect
    idle(); resume = 1; tick();
    chk("resume_run", pc, 32'h0000_0118);

    // absolute jump keeps top nibble of pc+4
    goto_pc(32'h3000_0000);
    jump = 1; jump_target = 26'h000_0010; tick();
    chk("jump_abs", pc, 32'h3000_0040);

    // halt overrides jump; halted ignores everything but resume
    goto_pc(32'h20);
    halt = 1; jump = 1; jump_target = 26'h123; tick();
    chk("halt_pc", pc, 32'h20);
    chk("halt_running", {31'b0, running}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      idle(); stall = 1; branch_taken = 1; branch_offset = 16'h0040; halt = 1;
      tick();
      chk("halted_pc", pc, 32'h20);
    end
    idle(); resume = 1; branch_taken = 1; branch_offset = 16'h0100; tick();
    chk("resume_pc", pc, 32'h20);
    idle(); tick();
    chk("after_resume_pc", pc, 32'h24);

    // wrap at top of address space
    goto_pc(32'hFFFF_FFFC);
    chk("pc_plus4_wrap", pc_plus4, 32'h0);
    tick();
    chk("pc_wrap", pc, 32'h0);

    // jump_reg wins, misaligned is sticky
    goto_pc(32'h1000_0040);
    jump = 1; jump_reg = 1; reg_target = 32'h2003; branch_taken = 1; tick();
    chk("jreg_pc", pc, 32'h2000);
    chk("jreg_mis", {31'b0, misaligned}, 32'd1);
    idle();
    for (int i = 0; i < 5; i++) tick();
    chk("mis_sticky", {31'b0, misaligned}, 32'd1);

    // reset while halted with stall
    halt = 1; tick();
    idle(); reset = 1; stall = 1; halt = 1; tick();
    chk("rst_halted_pc", pc, 32'h0);
    chk("rst_halted_running", {31'b0, running}, 32'd1);
    chk("rst_halted_retired", retired, 32'd0);
    chk("rst_halted_mis", {31'b0, misaligned}, 32'd0);

    // random traffic against the model
    for (int i = 0; i < 400; i++) begin
      reset         = ($urandom_range(63) == 0);
      halt          = ($urandom_range(15) == 0);
      resume        = ($urandom_range(3) == 0);
      stall         = ($urandom_range(4) == 0);
      branch_taken  = ($urandom_range(2) == 0);
      branch_offset = 16'($urandom);
      jump          = ($urandom_range(5) == 0);
      jump_target   = 26'($urandom);
      jump_reg      = ($urandom_range(7) == 0);
      reg_target    = $urandom;
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
